// File: rtl/arcade_input_cond.sv
// arcade_input_cond: keyboard/joystick conditioning with a timed coin pulse generator.
// Define PS2_KEYS_EN to compile in the PS/2 key decoder; otherwise only the joysticks drive the outputs.
module arcade_input_cond #(
  parameter logic [19:0] COIN_PULSE = 20'd600000,
  parameter logic [19:0] COIN_GAP   = 20'd600000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENA_6,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [7:0]  in0_reg,
  output logic [7:0]  in1_reg,
  output logic        coin_busy
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic req_prev_q, armed_q, busy_q, busy_d;
  logic [7:0] in0_q, in0_d, in1_q, in1_d, keys;
  logic [15:0] joy;
  logic up, down, left, right, fire, req1, req2, req, rise, idle_d, unused_bits;
`ifdef PS2_KEYS_EN
  logic [7:0] keys_q, keys_d;
  logic tog_q;
  // keys bits: 0 up, 1 down, 2 left, 3 right, 4 space, 5 ctrl, 6 F1, 7 F2
  always_comb begin
    keys_d = keys_q;
    if (ps2_key[10] != tog_q) begin
      if (ps2_key[7:0] == 8'h75) keys_d[0] = ps2_key[9];
      if (ps2_key[7:0] == 8'h72) keys_d[1] = ps2_key[9];
      if (ps2_key[7:0] == 8'h6B) keys_d[2] = ps2_key[9];
      if (ps2_key[7:0] == 8'h74) keys_d[3] = ps2_key[9];
      if (ps2_key[8:0] == 9'h029) keys_d[4] = ps2_key[9];
      if (ps2_key[8:0] == 9'h014) keys_d[5] = ps2_key[9];
      if (ps2_key[8:0] == 9'h005) keys_d[6] = ps2_key[9];
      if (ps2_key[8:0] == 9'h006) keys_d[7] = ps2_key[9];
    end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      keys_q <= 8'h00;
      tog_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      tog_q  <= ps2_key[10];
    end
  assign keys = keys_q;
  assign unused_bits = ^joy[15:7];
`else
  assign keys = 8'h00;
  assign unused_bits = ^{joy[15:7], ps2_key};
`endif
  assign joy   = joystick_0 | joystick_1;
  assign up    = rotate ? keys[2] | joy[1] : keys[0] | joy[3];
  assign down  = rotate ? keys[3] | joy[0] : keys[1] | joy[2];
  assign left  = rotate ? keys[1] | joy[2] : keys[2] | joy[1];
  assign right = rotate ? keys[0] | joy[3] : keys[3] | joy[0];
  assign fire  = keys[4] | keys[5] | joy[4];
  assign req1  = keys[6] | joy[5];
  assign req2  = keys[7] | joy[6];
  assign req   = req1 | req2;
  // armed_q blocks a request held across reset until it has been seen released
  assign rise  = req & ~req_prev_q & armed_q;
  assign idle_d = state_d == IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (rise) begin
        state_d = PULSE;
        cnt_d   = COIN_PULSE - 20'd1;
      end
    end else if (ENA_6) begin
      if (cnt_q != 20'd0) cnt_d = cnt_q - 20'd1;
      else if (state_q == PULSE) begin
        state_d = GAP;
        cnt_d   = COIN_GAP - 20'd1;
      end else state_d = IDLE;
    end
    in0_d  = ~{2'b00, state_d == PULSE, 1'b0, down, right, left, up};
    in1_d  = ~{1'b0, req2 & idle_d, req1 & idle_d, fire, 4'b0000};
    busy_d = ~idle_d;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 20'd0;
      req_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      in0_q      <= 8'hFF;
      in1_q      <= 8'hFF;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req;
      armed_q    <= armed_q | ~req;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
      busy_q     <= busy_d;
    end
  assign in0_reg   = in0_q;
  assign in1_reg   = in1_q;
  assign coin_busy = busy_q;
endmodule

// File: tb/tb_arcade_input_cond.sv
// tb_arcade_input_cond: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_arcade_input_cond;
  localparam int P = 4, G = 3;
  logic clk = 0, rst = 1, ena = 0, rot = 0;
  logic [10:0] ps2 = '0;
  logic [15:0] j0 = '0, j1 = '0;
  logic [7:0] in0, in1;
  logic busy;
  int checks = 0, errors = 0, cyc = 0;
  int pt, bt, leak;
  bit coin_prev, busy_prev, tog = 0;

  arcade_input_cond #(.COIN_PULSE(20'd4), .COIN_GAP(20'd3)) dut (
    .CLK(clk), .RESET(rst), .ENA_6(ena), .ps2_key(ps2), .joystick_0(j0),
    .joystick_1(j1), .rotate(rot), .in0_reg(in0), .in1_reg(in1), .coin_busy(busy));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    #1 ena = (cyc % 4 == 3);
    cyc++;
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: coin cycle as a count of remaining ENA_6 ticks (P+G down to 0)
  int m_left;
  bit m_prev_req, m_need_rel, m_prev_tog;
  bit ku, kd, kl, kr, ksp, kct, kf1, kf2;
  logic [7:0] e_in0 = 8'hFF, e_in1 = 8'hFF;
  bit e_busy;
  always @(posedge clk or posedge rst) begin
    logic [15:0] joy;
    bit u, d, l, r, f, r1, r2, rq, coin, idle;
    if (rst) begin
      m_left = 0; m_prev_req = 0; m_need_rel = 1; m_prev_tog = 0;
      {ku, kd, kl, kr, ksp, kct, kf1, kf2} = '0;
      e_in0 = 8'hFF; e_in1 = 8'hFF; e_busy = 0;
    end else begin
      joy = j0 | j1;
      u = rot ? (kl | joy[1]) : (ku | joy[3]);
      d = rot ? (kr | joy[0]) : (kd | joy[2]);
      l = rot ? (kd | joy[2]) : (kl | joy[1]);
      r = rot ? (ku | joy[3]) : (kr | joy[0]);
      f = ksp | kct | joy[4];
      r1 = kf1 | joy[5];
      r2 = kf2 | joy[6];
      rq = r1 | r2;
      if (m_left > 0) begin
        if (ena) m_left--;
      end else if (rq && !m_prev_req && !m_need_rel) m_left = P + G;
      if (!rq) m_need_rel = 0;
      m_prev_req = rq;
      coin = m_left > G;
      idle = m_left == 0;
      e_in0 = ~{2'b00, coin, 1'b0, d, r, l, u};
      e_in1 = ~{1'b0, r2 & idle, r1 & idle, f, 4'b0000};
      e_busy = !idle;
`ifdef PS2_KEYS_EN
      if (ps2[10] != m_prev_tog) begin
        case (ps2[7:0])
          8'h75: ku = ps2[9];
          8'h72: kd = ps2[9];
          8'h6B: kl = ps2[9];
          8'h74: kr = ps2[9];
          default: ;
        endcase
        if (!ps2[8])
          case (ps2[7:0])
            8'h29: ksp = ps2[9];
            8'h14: kct = ps2[9];
            8'h05: kf1 = ps2[9];
            8'h06: kf2 = ps2[9];
            default: ;
          endcase
      end
`endif
      m_prev_tog = ps2[10];
    end
  end

  always @(negedge clk) begin
    chk("model in0_reg", in0, e_in0);
    chk("model in1_reg", in1, e_in1);
    chk("model coin_busy", {7'd0, busy}, {7'd0, e_busy});
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic key(bit pressed, logic [8:0] code);
    tog = ~tog;
    ps2 = {tog, pressed, code};
  endtask

  // Counts ENA_6 ticks spent in PULSE / busy and any start leaking out while busy
  task automatic observe(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ena && coin_prev) pt++;
      if (ena && busy_prev) bt++;
      if (busy && !in1[5]) leak++;
      coin_prev = !in0[5];
      busy_prev = busy;
    end
    #1;
  endtask

  task automatic clear_counts();
    pt = 0; bt = 0; leak = 0;
    observe(1);
  endtask

  initial begin
    @(negedge clk);
    chk("reset in0", in0, 8'hFF);
    chk("reset in1", in1, 8'hFF);
    chk("reset busy", {7'd0, busy}, 8'd0);
    #1 rst = 0;
    step(3);
    j0 = 16'h0008;
    @(negedge clk) chk("up rot0", in0, 8'hFE);
    #1 rot = 1;
    @(negedge clk) chk("up rot1", in0, 8'hFB);
    #1 rot = 0; j0 = 0;
    step(2);
`ifdef PS2_KEYS_EN
    key(1, 9'h075);
    @(negedge clk) chk("ps2 up lat1", in0, 8'hFF);
    @(negedge clk) chk("ps2 up lat2", in0, 8'hFE);
    #1 key(0, 9'h075);
    step(1);
    @(negedge clk) chk("ps2 up release", in0, 8'hFF);
    #1 key(1, 9'h175);
    step(1);
    @(negedge clk) chk("ps2 e0 up", in0, 8'hFE);
    #1 key(0, 9'h175);
    step(1);
    @(negedge clk) chk("ps2 e0 release", in0, 8'hFF);
    #1 key(1, 9'h029);
    step(1);
    @(negedge clk) chk("ps2 space fire", in1, 8'hEF);
    #1 key(0, 9'h029);
    step(3);
`else
    key(1, 9'h029);
    step(3);
    chk("no ps2 space", in1, 8'hFF);
    step(1);
`endif
    clear_counts();
    j1[5] = 1;
    observe(40);
    chk("coin pulse ticks", pt[7:0], 8'd4);
    chk("coin busy ticks", bt[7:0], 8'd7);
    chk("start leak", leak[7:0], 8'd0);
    chk("start after coin", in1, 8'hDF);
    chk("coin low after cycle", in0, 8'hFF);
    j1 = 0;
    step(3);
    clear_counts();
    j0[5] = 1;
    observe(8);
`ifdef PS2_KEYS_EN
    key(1, 9'h006);
`else
    j0[6] = 1;
`endif
    observe(40);
    chk("second req pulse ticks", pt[7:0], 8'd4);
    chk("second req busy ticks", bt[7:0], 8'd7);
    observe(20);
    chk("held req no retrigger", bt[7:0], 8'd7);
    chk("both starts after coin", in1, 8'h9F);
    j0 = 0;
`ifdef PS2_KEYS_EN
    key(0, 9'h006);
`endif
    step(4);
    clear_counts();
    j0[5] = 1;
    observe(6);
    rst = 1;
    #1;
    chk("async reset in0", in0, 8'hFF);
    chk("async reset busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    #1 rst = 0;
    clear_counts();
    observe(40);
    chk("held start after reset", bt[7:0], 8'd0);
    j0 = 0;
    step(3);
    clear_counts();
    j0[5] = 1;
    observe(40);
    chk("re-press after reset", pt[7:0], 8'd4);
    j0 = 0;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arcade_input_cond.md
ARCADE_INPUT_COND -- requirements
Module: arcade_input_cond

Interface
REQ-001 SHALL have parameter COIN_PULSE, default 20'd600000, coin-active length in ENA_6 ticks (100 ms).
REQ-002 SHALL have parameter COIN_GAP, default 20'd600000, coin-inactive recovery length in ENA_6 ticks.
REQ-003 SHALL have port CLK  in  1  system clock.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ENA_6  in  1  6 MHz clock enable.
REQ-006 SHALL have port ps2_key  in  11  [10] toggles per event, [9] pressed, [8:0] scan code.
REQ-007 SHALL have port joystick_0  in  16  player-1 pad, [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2.
REQ-008 SHALL have port joystick_1  in  16  player-2 pad, same map.
REQ-009 SHALL have port rotate  in  1  1 = horizontal orientation remap.
REQ-010 SHALL have port in0_reg  out  8  active-low ~{2'b00, coin, 1'b0, down, right, left, up}.
REQ-011 SHALL have port in1_reg  out  8  active-low ~{1'b0, start2, start1, fire, 4'b0000}.
REQ-012 SHALL have port coin_busy  out  1  high whenever coin FSM is not IDLE.

Function
REQ-013 SHALL detect a key event when ps2_key[10] differs from its value registered one CLK earlier; one event per toggle.
REQ-014 On an event SHALL set the matching key flag to ps2_key[9]: codes x75 up, x72 down, x6B left, x74 right (bit 8 ignored); 029 space, 014 ctrl, 005 F1, 006 F2 (bit 8 must be 0). All other codes are ignored.
REQ-015 Space and ctrl SHALL be separate flags, ORed into fire.
REQ-016 SHALL form joy = joystick_0 | joystick_1.
REQ-017 With rotate=0 the mapping SHALL be up=kU|joy[3], down=kD|joy[2], left=kL|joy[1], right=kR|joy[0].
REQ-018 With rotate=1 the mapping SHALL be up=kL|joy[1], down=kR|joy[0], left=kD|joy[2], right=kU|joy[3].
REQ-019 SHALL compute fire = space|ctrl|joy[4], req1 = F1|joy[5], req2 = F2|joy[6].
REQ-020 Coin FSM SHALL have states IDLE, PULSE, GAP, with a 20-bit down-counter decremented only on ENA_6.
REQ-021 IDLE -> PULSE SHALL occur on a rising edge of (req1|req2), loading COIN_PULSE-1.
REQ-022 PULSE -> GAP SHALL occur on the ENA_6 tick where the counter is 0, loading COIN_GAP-1.
REQ-023 GAP -> IDLE SHALL occur on the ENA_6 tick where the counter is 0.
REQ-024 coin SHALL be 1 only in PULSE, for exactly COIN_PULSE ENA_6 ticks.
REQ-025 Request edges arriving in PULSE or GAP SHALL be dropped, not queued; a request held through GAP SHALL NOT retrigger at the GAP -> IDLE transition.
REQ-026 start1 and start2 SHALL be req1 and req2 gated by (state==IDLE), so a held start reaches the core only after the coin cycle completes.
REQ-027 in0_reg, in1_reg and coin_busy SHALL be registered; latency from joystick input to output is 1 CLK, and from ps2 toggle to output is 2 CLK.

Reset
REQ-028 While RESET=1: all key flags 0; FSM IDLE; counter 0; previous-toggle and previous-request registers 0; in0_reg=8'hFF; in1_reg=8'hFF; coin_busy=0.
REQ-029 RESET asserted mid-PULSE or mid-GAP SHALL abort the cycle immediately (asynchronously); a request still held after release SHALL NOT start a new coin cycle until it is released and pressed again.

Configuration
REQ-030 With PS2_KEYS_EN defined, the PS/2 decoder SHALL be compiled in.
REQ-031 With PS2_KEYS_EN undefined, ps2_key SHALL be ignored, all key flags SHALL be constant 0, and only the joysticks drive the outputs.

Verification (COIN_PULSE=4, COIN_GAP=3, ENA_6 every 4th CLK)
REQ-032 joystick_0=16'h0008, rotate=0 -> in0_reg=8'hFE after 1 CLK; with rotate=1 -> in0_reg=8'hFB.
REQ-033 ps2_key toggled with {1,0x075} then {0,0x075} -> in0_reg goes to 8'hFE 2 CLK after the first toggle and back to 8'hFF after the second; code 0x175 gives the same result.
REQ-034 joystick_1[5] held -> in0_reg[5]=0 for exactly 4 ENA_6 ticks, then 3 ticks of GAP with in1_reg[5]=1, then in1_reg[5]=0 in IDLE; coin_busy high for 7 ticks.
REQ-035 F2 pressed during PULSE with joy[5] already held -> no second coin pulse; coin cycle length unchanged.
REQ-036 RESET pulsed during PULSE -> in0_reg=8'hFF immediately, coin_busy=0; held start yields no coin until re-pressed.
REQ-037 Build without PS2_KEYS_EN, ps2_key event {1,0x029} -> in1_reg stays 8'hFF.
